// File: rtl/meteor_pkg.sv
// Shared constants and types for the meteor field.
// Holds screen geometry, default meteor half-size, LFSR seed, the fixed
// spawn-column table and the per-slot state struct.
package meteor_pkg;

    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned SCREEN_H     = 480;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCORE_W      = 16;
    localparam int unsigned METEOR_S_DEF = 8;
    localparam int unsigned NUM_COLS     = 4;

    localparam logic [COORD_W-1:0] LFSR_SEED = 10'h2A5;

    // Entry 0 is the first column used after reset.
    localparam logic [NUM_COLS-1:0][COORD_W-1:0] COL_TABLE =
        {10'd560, 10'd400, 10'd240, 10'd80};

    typedef struct packed {
        logic               alive;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

endpackage

// File: rtl/meteor_field_if.sv
// Bullet-stage link: bullet position/size into the meteor field and the
// registered hit pulse back out.
//   master : bullet stage (drives bullet_*, receives bullet_hit)
//   slave  : meteor field (receives bullet_*, drives bullet_hit)
interface meteor_field_if;
    import meteor_pkg::*;

    logic               bullet_active;
    logic [COORD_W-1:0] bullet_X_out;
    logic [COORD_W-1:0] bullet_Y_out;
    logic [COORD_W-1:0] bullet_size;
    logic               bullet_hit;

    modport master (
        output bullet_active, bullet_X_out, bullet_Y_out, bullet_size,
        input  bullet_hit
    );

    modport slave (
        input  bullet_active, bullet_X_out, bullet_Y_out, bullet_size,
        output bullet_hit
    );

endinterface

// File: rtl/meteor_hit_cmp.sv
// Single-slot bullet/meteor box overlap test (combinational).
// Ports: alive_i, active_i gate the test; bx_i/by_i bullet centre,
// size_i bullet half-size, mx_i/my_i meteor centre; overlap_c_o result.
// Differences use one extra bit as sign so nothing wraps.
module meteor_hit_cmp
    import meteor_pkg::*;
#(
    parameter int unsigned METEOR_S = METEOR_S_DEF
) (
    input  logic               alive_i,
    input  logic               active_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    input  logic [COORD_W-1:0] size_i,
    input  logic [COORD_W-1:0] mx_i,
    input  logic [COORD_W-1:0] my_i,
    output logic               overlap_c_o
);
    localparam int unsigned DW = COORD_W + 1;

    logic signed [DW-1:0] dx_c, dy_c;
    logic [DW-1:0]        adx_c, ady_c, lim_c;

    always_comb begin
        dx_c  = $signed({1'b0, bx_i}) - $signed({1'b0, mx_i});
        dy_c  = $signed({1'b0, by_i}) - $signed({1'b0, my_i});
        adx_c = dx_c[DW-1] ? $unsigned(-dx_c) : $unsigned(dx_c);
        ady_c = dy_c[DW-1] ? $unsigned(-dy_c) : $unsigned(dy_c);
        lim_c = {1'b0, size_i} + DW'(METEOR_S);
        overlap_c_o = alive_i && active_i && (adx_c <= lim_c) && (ady_c <= lim_c);
    end

endmodule

// File: rtl/meteor_field.sv
// Meteor field: falling meteor slots, periodic spawning, bullet hits and score.
// Ports: frame_clk, Reset (async, active-high); bullet (meteor_field_if.slave);
// meteor_alive/meteor_x/meteor_y per-slot state; score destroyed-meteor count.
// Build option: define METEOR_LFSR_SPAWN_EN to take spawn x from a 10-bit LFSR
// instead of the fixed column table.
module meteor_field
    import meteor_pkg::*;
#(
    parameter int unsigned NUM_METEORS  = 4,
    parameter int unsigned METEOR_S     = METEOR_S_DEF,
    parameter int unsigned FALL_SPEED   = 1,
    parameter int unsigned SPAWN_PERIOD = 60,
    parameter int unsigned Y_MAX        = 479
) (
    input  logic                                 frame_clk,
    input  logic                                 Reset,
    meteor_field_if.slave                        bullet,
    output logic [NUM_METEORS-1:0]               meteor_alive,
    output logic [NUM_METEORS-1:0][COORD_W-1:0]  meteor_x,
    output logic [NUM_METEORS-1:0][COORD_W-1:0]  meteor_y,
    output logic [SCORE_W-1:0]                   score
);
    localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int unsigned YW    = COORD_W + 1;
    localparam logic [YW-1:0]      Y_LIMIT = YW'(Y_MAX - METEOR_S);
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(SPAWN_PERIOD - 1);

    slot_t [NUM_METEORS-1:0] slots_q, slots_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic                    hit_q, hit_d;

    logic [NUM_METEORS-1:0]  overlap_c;
    logic [COORD_W-1:0]      spawn_x_c;
    logic [YW-1:0]           y_nx_c;
    logic                    hit_found_c, spawn_done_c;
    logic [NUM_METEORS-1:0]  kill_c;

`ifdef METEOR_LFSR_SPAWN_EN
    logic [COORD_W-1:0] lfsr_q, lfsr_d;
`else
    logic [1:0]         col_q, col_d;
`endif

    // One overlap comparator per slot, on registered meteor positions.
    for (genvar g = 0; g < NUM_METEORS; g++) begin : g_slot
        meteor_hit_cmp #(.METEOR_S(METEOR_S)) u_cmp (
            .alive_i     (slots_q[g].alive),
            .active_i    (bullet.bullet_active),
            .bx_i        (bullet.bullet_X_out),
            .by_i        (bullet.bullet_Y_out),
            .size_i      (bullet.bullet_size),
            .mx_i        (slots_q[g].x),
            .my_i        (slots_q[g].y),
            .overlap_c_o (overlap_c[g])
        );

        assign meteor_alive[g] = slots_q[g].alive;
        assign meteor_x[g]     = slots_q[g].x;
        assign meteor_y[g]     = slots_q[g].y;
    end

    assign score             = score_q;
    assign bullet.bullet_hit = hit_q;

    // Spawn column source.
    always_comb begin
`ifdef METEOR_LFSR_SPAWN_EN
        lfsr_d    = {lfsr_q[COORD_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
        spawn_x_c = COORD_W'(METEOR_S + (32'(lfsr_q) % (SCREEN_W - 2 * METEOR_S)));
`else
        spawn_x_c = COL_TABLE[col_q];
`endif
    end

    // Next-state: hit select, fall/fall-out, spawn, score.
    always_comb begin
        slots_d      = slots_q;
        cnt_d        = cnt_q + CNT_W'(1);
        score_d      = score_q;
        hit_d        = 1'b0;
        hit_found_c  = 1'b0;
        spawn_done_c = 1'b0;
        kill_c       = '0;
        y_nx_c       = '0;
`ifndef METEOR_LFSR_SPAWN_EN
        col_d        = col_q;
`endif

        // Lowest-index overlap wins; no new hit in the frame after a pulse.
        for (int i = 0; i < NUM_METEORS; i++) begin
            if (!hit_found_c && !hit_q && overlap_c[i]) begin
                hit_found_c = 1'b1;
                kill_c[i]   = 1'b1;
            end
        end

        for (int i = 0; i < NUM_METEORS; i++) begin
            if (slots_q[i].alive) begin
                y_nx_c = {1'b0, slots_q[i].y} + YW'(FALL_SPEED);
                if (kill_c[i] || (y_nx_c > Y_LIMIT)) begin
                    slots_d[i].alive = 1'b0;
                end else begin
                    slots_d[i].y = y_nx_c[COORD_W-1:0];
                end
            end
        end

        // Free means free at frame start, so just-freed slots wait a period.
        if (cnt_q == CNT_TOP) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_METEORS; i++) begin
                if (!spawn_done_c && !slots_q[i].alive) begin
                    spawn_done_c = 1'b1;
                    slots_d[i]   = slot_t'{alive: 1'b1, x: spawn_x_c, y: COORD_W'(METEOR_S)};
                end
            end
        end

`ifndef METEOR_LFSR_SPAWN_EN
        if (spawn_done_c) begin
            col_d = col_q + 2'd1;
        end
`endif

        if (hit_found_c) begin
            hit_d = 1'b1;
            if (score_q != '1) begin
                score_d = score_q + SCORE_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            slots_q <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            hit_q   <= 1'b0;
`ifdef METEOR_LFSR_SPAWN_EN
            lfsr_q  <= LFSR_SEED;
`else
            col_q   <= '0;
`endif
        end else begin
            slots_q <= slots_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            hit_q   <= hit_d;
`ifdef METEOR_LFSR_SPAWN_EN
            lfsr_q  <= lfsr_d;
`else
            col_q   <= col_d;
`endif
        end
    end

endmodule

// File: tb/tb_meteor_field.sv
// Directed bench for meteor_field (default build, default parameters).
// Edge numbers below count rising edges since reset release.
module tb_meteor_field;

    logic                 frame_clk = 1'b0;
    logic                 Reset;
    logic [3:0]           alive;
    logic [3:0][9:0]      mx;
    logic [3:0][9:0]      my;
    logic [15:0]          score;

    int checks   = 0;
    int failures = 0;
    int frame    = 0;

    meteor_field_if bus();

    meteor_field dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .bullet       (bus.slave),
        .meteor_alive (alive),
        .meteor_x     (mx),
        .meteor_y     (my),
        .score        (score)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge frame_clk);
        @(negedge frame_clk);
        frame += n;
    endtask

    task automatic run_to(input int e);
        tick(e - frame);
    endtask

    task automatic set_bullet(input logic act, input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] sz);
        bus.bullet_active = act;
        bus.bullet_X_out  = x;
        bus.bullet_Y_out  = y;
        bus.bullet_size   = sz;
    endtask

    initial begin
        Reset = 1'b1;
        set_bullet(1'b0, 10'd0, 10'd0, 10'd0);
        @(negedge frame_clk);
        @(negedge frame_clk);
        check_eq("rst_hit",   32'(bus.bullet_hit), 32'd0);
        check_eq("rst_alive", 32'(alive), 32'd0);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_xy",    32'({mx, my} != '0), 32'd0);

        Reset = 1'b0;
        frame = 0;

        // First spawn exactly at edge 60.
        run_to(59);
        check_eq("pre_spawn_alive", 32'(alive), 32'd0);
        run_to(60);
        check_eq("spawn0_alive", 32'(alive), 32'b0001);
        check_eq("spawn0_y", 32'(my[0]), 32'd8);
        check_eq("spawn0_x", 32'(mx[0]), 32'd80);
        run_to(61);
        check_eq("spawn0_move", 32'(my[0]), 32'd9);

        // Bullet on slot0 centre, size 3.
        set_bullet(1'b1, 10'd80, 10'd9, 10'd3);
        run_to(62);
        check_eq("hit_pulse", 32'(bus.bullet_hit), 32'd1);
        check_eq("hit_alive", 32'(alive), 32'd0);
        check_eq("hit_score", 32'(score), 32'd1);
        set_bullet(1'b0, 10'd0, 10'd0, 10'd0);
        run_to(63);
        check_eq("hit_pulse_end", 32'(bus.bullet_hit), 32'd0);
        check_eq("hit_score_hold", 32'(score), 32'd1);

        // Fill all slots; columns continue 240, 400, 560, 80.
        run_to(120);
        check_eq("spawn_slot0_x", 32'(mx[0]), 32'd240);
        run_to(180);
        check_eq("spawn_slot1", 32'(alive), 32'b0011);
        check_eq("spawn_slot1_x", 32'(mx[1]), 32'd400);
        run_to(240);
        check_eq("spawn_slot2_x", 32'(mx[2]), 32'd560);
        run_to(300);
        check_eq("all_alive", 32'(alive), 32'b1111);
        check_eq("col_wrap_x", 32'(mx[3]), 32'd80);

        // Spawn point with no free slot.
        run_to(360);
        check_eq("nospawn_alive", 32'(alive), 32'b1111);
        check_eq("nospawn_x0", 32'(mx[0]), 32'd240);
        check_eq("nospawn_y0", 32'(my[0]), 32'd248);
        check_eq("nospawn_y3", 32'(my[3]), 32'd68);

        // Slot1 (400,188) and slot2 (560,128) both overlapped.
        set_bullet(1'b1, 10'd480, 10'd158, 10'd100);
        run_to(361);
        check_eq("multi_alive", 32'(alive), 32'b1101);
        check_eq("multi_score", 32'(score), 32'd2);
        check_eq("multi_hit", 32'(bus.bullet_hit), 32'd1);
        run_to(362);
        check_eq("no_rehit", 32'(bus.bullet_hit), 32'd0);
        check_eq("no_rehit_alive", 32'(alive), 32'b1101);
        check_eq("no_rehit_score", 32'(score), 32'd2);
        run_to(363);
        check_eq("rehit_alive", 32'(alive), 32'b1001);
        check_eq("rehit_score", 32'(score), 32'd3);
        set_bullet(1'b0, 10'd0, 10'd0, 10'd0);

        run_to(420);
        check_eq("refill_alive", 32'(alive), 32'b1011);
        check_eq("refill_x1", 32'(mx[1]), 32'd240);

        // Slot0 (spawned at edge 120) reaches y=471, then falls out.
        run_to(583);
        check_eq("fall_pre_alive", 32'(alive[0]), 32'd1);
        check_eq("fall_pre_y", 32'(my[0]), 32'd471);
        run_to(584);
        check_eq("fall_alive", 32'(alive), 32'b1110);
        check_eq("fall_score", 32'(score), 32'd3);
        check_eq("fall_hit", 32'(bus.bullet_hit), 32'd0);

        // Saturation: preload score, then hit slot3 at (80,293).
        run_to(585);
        force dut.score_q = 16'hFFFF;
        #1;
        release dut.score_q;
        set_bullet(1'b1, 10'd80, 10'd293, 10'd3);
        run_to(586);
        check_eq("sat_score", 32'(score), 32'hFFFF);
        check_eq("sat_hit", 32'(bus.bullet_hit), 32'd1);
        check_eq("sat_alive", 32'(alive), 32'b0110);

        // Reset in the middle of the pulse.
        Reset = 1'b1;
        set_bullet(1'b0, 10'd0, 10'd0, 10'd0);
        #1;
        check_eq("midrst_hit", 32'(bus.bullet_hit), 32'd0);
        check_eq("midrst_alive", 32'(alive), 32'd0);
        check_eq("midrst_score", 32'(score), 32'd0);
        check_eq("midrst_xy", 32'({mx, my} != '0), 32'd0);
        @(negedge frame_clk);
        Reset = 1'b0;
        frame = 0;
        run_to(3);
        check_eq("postrst_score", 32'(score), 32'd0);
        check_eq("postrst_hit", 32'(bus.bullet_hit), 32'd0);
        run_to(60);
        check_eq("postrst_alive", 32'(alive), 32'b0001);
        check_eq("postrst_x", 32'(mx[0]), 32'd80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/meteor_field.md
METEOR_FIELD -- requirements
Module: meteor_field

Interface
REQ-001 frame_clk  input  1  frame-rate clock; all state advances on its rising edge.
REQ-002 Reset  input  1  reset, asynchronous, active-high.
REQ-003 bullet_active  input  1  bullet in flight, from the bullet stage.
REQ-004 bullet_X_out, bullet_Y_out  input  10 each  bullet centre, from the bullet stage.
REQ-005 bullet_size  input  10  bullet half-size.
REQ-006 bullet_hit  output  1  registered one-frame pulse; feeds the bullet stage's bullet_hit.
REQ-007 meteor_alive  output  NUM_METEORS  per-slot alive flags.
REQ-008 meteor_x, meteor_y  output  NUM_METEORS x 10 each  per-slot meteor centre.
REQ-009 score  output  16  count of destroyed meteors.
REQ-010 Parameter NUM_METEORS, default 4, number of meteor slots.
REQ-011 Parameter METEOR_S, default 8, meteor half-size.
REQ-012 Parameter FALL_SPEED, default 1, y increment per frame.
REQ-013 Parameter SPAWN_PERIOD, default 60, frames between spawn attempts.
REQ-014 Parameter Y_MAX, default 479, bottom screen row.

Function
REQ-015 Each alive slot SHALL add FALL_SPEED to its meteor_y once per frame.
REQ-016 A slot whose next y exceeds Y_MAX-METEOR_S SHALL clear its alive flag and SHALL NOT change score.
REQ-017 Overlap SHALL be bullet_active AND |bx-mx| <= bullet_size+METEOR_S AND |by-my| <= bullet_size+METEOR_S, on current registered values.
REQ-018 Overlap SHALL be evaluated only for alive slots.
REQ-019 Differences SHALL be computed in 11-bit signed arithmetic, so no wrap-around occurs.
REQ-020 On overlap, the lowest-index hit slot SHALL clear alive at the next edge.
REQ-021 On overlap, bullet_hit SHALL be 1 for exactly the next frame, then 0.
REQ-022 On overlap, score SHALL increment by 1.
REQ-023 Overlap with multiple slots SHALL destroy only the lowest-index slot and SHALL increment score by 1.
REQ-024 bullet_hit SHALL NOT reassert in the frame immediately following a hit pulse.
REQ-025 score SHALL saturate at 16'hFFFF.
REQ-026 A frame counter SHALL count 0..SPAWN_PERIOD-1 and wrap.
REQ-027 At count SPAWN_PERIOD-1, the lowest-index free slot SHALL spawn with alive=1, y=METEOR_S, and x from REQ-033/034.
REQ-028 If no slot is free at a spawn point, the spawn SHALL be skipped and the counter SHALL still wrap.
REQ-029 A slot freed by hit or fall-out in a frame SHALL NOT be re-spawned in that same frame.
REQ-030 A spawned slot SHALL first move on the following frame.

Reset
REQ-031 Reset SHALL asynchronously clear bullet_hit, meteor_alive, meteor_x, meteor_y, score, the frame counter and internal hit state to 0.
REQ-032 Reset asserted mid-pulse or mid-descent SHALL abort immediately, with no score update on release.

Configuration
REQ-033 With METEOR_LFSR_SPAWN_EN defined, spawn x SHALL come from a 10-bit maximal LFSR (seed 10'h2A5, stepped every frame), mapped as METEOR_S + (lfsr mod (640-2*METEOR_S)).
REQ-034 Without METEOR_LFSR_SPAWN_EN, spawn x SHALL cycle through fixed columns 80, 240, 400, 560 in order, advancing per successful spawn; the LFSR SHALL be absent.

Structure
REQ-035 Package meteor_pkg SHALL hold screen constants (640, 480), default METEOR_S, the LFSR seed, the column table and the slot struct typedef (alive, x, y).
REQ-036 Sub-module meteor_hit_cmp SHALL hold the single-slot combinational overlap compare, instantiated once per slot.

Verification
REQ-037 Reset released, no bullet -> first spawn after 60 frames: slot0 alive, y=8; y=9 one frame later.
REQ-038 Bullet active at (X,Y) equal to alive slot0 centre, size 3 -> next frame: bullet_hit=1, slot0 alive=0, score=1; following frame: bullet_hit=0.
REQ-039 Slots 1 and 2 both overlapped by the bullet -> only slot1 cleared, score +1, slot2 remains alive.
REQ-040 Meteor descends unhit -> alive clears when next y > 471; score unchanged; bullet_hit stays 0.
REQ-041 score preloaded to 16'hFFFF, then a hit -> score stays 16'hFFFF; bullet_hit still pulses.
REQ-042 All 4 slots alive at a spawn point -> no spawn; then Reset asserted during a hit pulse -> all outputs 0 immediately.
